// File: rtl/pipe_ripple_adder_pkg.sv
// Shared configuration for the pipelined ripple-carry adder:
// default geometry and the slice-width helper.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Bits handled by each pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipe_ripple_adder_rca_slice.sv
// One pipeline slice: a purely combinational ripple chain of full adders.
// Also exposes the carry into its top bit so the last slice can form the
// signed overflow flag.
module rca_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          c_msb_in
);

    logic [SW:0] c;

    // Full-adder chain, LSB first; c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SW; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[SW];
    assign c_msb_in = c[SW - 1];

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder. Stage k adds bit slice k of the operands
// with the registered carry of stage k-1. Each stage register carries the
// operands forward (skew) and the sum slices finished so far (de-skew), so
// the last stage register holds the complete result.
//
// Handshake: a transfer happens on a port when its valid and ready are both
// high at a rising edge. Valid, once raised by the pipeline, holds together
// with sum/cout/ovf until out_ready. in_ready is !(out_valid && !out_ready)
// and never looks at in_valid. A stall freezes every stage, bubbles
// included; otherwise every stage advances, so bubbles move like data.
module pipe_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipe_ripple_adder: WIDTH must be a positive multiple of STAGES");
    end

    // Per-stage registers. Operand words keep their consumed low slices;
    // those bits are simply never read again.
    logic             valid_q [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             ovf_q;

    // Inputs seen by each stage's adder (stage 0 sees the ports).
    logic             st_valid [STAGES];
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic             st_cin   [STAGES];
    logic [WIDTH-1:0] st_sum   [STAGES];

    logic [SW-1:0]    sl_s    [STAGES];
    logic             sl_cout [STAGES];
    logic             sl_cmsb [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];

    logic stall;

    assign stall    = valid_q[LAST] && !out_ready;
    assign in_ready = !stall;

    // Route each stage's inputs from the ports or the previous stage register.
    always_comb begin
        st_valid[0] = in_valid;
        st_a[0]     = a;
        st_b[0]     = b;
        st_cin[0]   = cin;
        st_sum[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            st_valid[k] = valid_q[k - 1];
            st_a[k]     = a_q[k - 1];
            st_b[k]     = b_q[k - 1];
            st_cin[k]   = carry_q[k - 1];
            st_sum[k]   = sum_q[k - 1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        rca_slice #(
            .SW(SW)
        ) u_rca (
            .a        (st_a[k][k*SW +: SW]),
            .b        (st_b[k][k*SW +: SW]),
            .cin      (st_cin[k]),
            .s        (sl_s[k]),
            .cout     (sl_cout[k]),
            .c_msb_in (sl_cmsb[k])
        );
    end

    // Merge each stage's freshly computed slice into the partial sum it carries.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k]              = st_sum[k];
            sum_d[k][k*SW +: SW]  = sl_s[k];
        end
    end

    // Pipeline registers: clear on reset, hold on stall, otherwise advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= st_valid[k];
                a_q[k]     <= st_a[k];
                b_q[k]     <= st_b[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= sl_cout[k];
            end
            ovf_q <= sl_cout[LAST] ^ sl_cmsb[LAST];
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = ovf_q;

endmodule
